calc_rr_scheduler: RTL and testbench

//  Shares one calculator (queue + ALU) among N requesters, round-robin.

---
 rtl/calc_rr_scheduler_pkg.sv | 22 ++
 rtl/calc_rr_scheduler_rr_arbiter.sv | 33 +++
 rtl/calc_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_calc_rr_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin calculator scheduler.
// Holds FSM state encoding, default widths and calculator opcodes.
package calc_rr_scheduler_pkg;

    localparam int unsigned DataWDef = 8;
    localparam int unsigned OpWDef   = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    localparam logic [2:0] OpPush = 3'd0;
    localparam logic [2:0] OpPop  = 3'd1;
    localparam logic [2:0] OpAdd  = 3'd2;
    localparam logic [2:0] OpSub  = 3'd3;
    localparam logic [2:0] OpMul  = 3'd4;
    localparam logic [2:0] OpDiv  = 3'd5;

endpackage

// File: rtl/calc_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping modulo N. Produces a one-hot grant and its index.
module rr_arbiter
    import calc_rr_scheduler_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gidx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gidx     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/calc_rr_scheduler.sv
// Round-robin scheduler sharing one calculator among N requesters.
// One request in flight: accept, apply, wait RESP_LAT, sample, respond.
module calc_rr_scheduler
    import calc_rr_scheduler_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DATA_W   = DataWDef,
    parameter int unsigned OP_W     = OpWDef,
    parameter int unsigned RESP_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_valid,
    input  logic [N*OP_W-1:0]   req_op,
    input  logic [N*DATA_W-1:0] req_data,
    output logic [N-1:0]        req_ready,
    output logic [N-1:0]        rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_empty,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   calc_in,
    output logic [OP_W-1:0]     calc_op,
    output logic                calc_apply,
    input  logic [DATA_W-1:0]   calc_tail,
    input  logic                calc_empty,
    input  logic                calc_valid,
    output logic                busy
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(RESP_LAT + 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       gidx_q, gidx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   in_q, in_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                empty_q, empty_d;
    logic                err_q, err_d;

    logic [N-1:0]        arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_data;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req  (req_valid),
        .ptr  (ptr_q),
        .gnt  (arb_gnt),
        .gidx (arb_idx)
    );

    // One-hot AND-OR mux of the granted requester's operand
    always_comb begin
        sel_op   = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_gnt[i]) begin
                sel_op   = sel_op   | req_op[i*OP_W +: OP_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        cnt_d     = cnt_q;
        in_d      = in_q;
        op_d      = op_q;
        rdata_d   = rdata_q;
        empty_d   = empty_q;
        err_d     = err_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                // Ready is combinational; held low while reset is asserted
                req_ready = rst ? arb_gnt : '0;
                if (|req_valid) begin
                    gidx_d  = arb_idx;
                    in_d    = sel_data;
                    op_d    = sel_op;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CW'(RESP_LAT);
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    rdata_d = calc_tail;
                    empty_d = calc_empty;
                    err_d   = ~calc_valid;
                    state_d = StResp;
                end
            end
            StResp: begin
                ptr_d   = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            in_q    <= '0;
            op_q    <= '0;
            rdata_q <= '0;
            empty_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign calc_in    = in_q;
    assign calc_op    = op_q;
    assign calc_apply = (state_q == StIssue);
    assign busy       = (state_q != StIdle);
    assign rsp_valid  = (state_q == StResp) ? (N'(1) << gidx_q) : '0;
    assign rsp_data   = rdata_q;
    assign rsp_empty  = empty_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_calc_rr_scheduler.sv
// Directed bench for calc_rr_scheduler with a small stack-calculator model
// attached to the calc_* pins.
module tb_calc_rr_scheduler;
    import calc_rr_scheduler_pkg::*;

    localparam int N        = 4;
    localparam int DATA_W   = 8;
    localparam int OP_W     = 3;
    localparam int RESP_LAT = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N*OP_W-1:0]   req_op;
    logic [N*DATA_W-1:0] req_data;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_empty;
    logic                rsp_err;
    logic [DATA_W-1:0]   calc_in;
    logic [OP_W-1:0]     calc_op;
    logic                calc_apply;
    logic [DATA_W-1:0]   calc_tail;
    logic                calc_empty;
    logic                calc_valid;
    logic                busy;

    int vectors    = 0;
    int miscompares = 0;

    calc_rr_scheduler #(
        .N        (N),
        .DATA_W   (DATA_W),
        .OP_W     (OP_W),
        .RESP_LAT (RESP_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_empty  (rsp_empty),
        .rsp_err    (rsp_err),
        .calc_in    (calc_in),
        .calc_op    (calc_op),
        .calc_apply (calc_apply),
        .calc_tail  (calc_tail),
        .calc_empty (calc_empty),
        .calc_valid (calc_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stack calculator: tail is top of stack (0 when empty), valid=0 on a bad op
    logic [7:0] stk [16];
    int         sp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp         <= 0;
            calc_tail  <= 8'h00;
            calc_empty <= 1'b1;
            calc_valid <= 1'b1;
        end else if (calc_apply) begin
            case (calc_op)
                OpPush: begin
                    if (sp < 16) begin
                        stk[sp]    <= calc_in;
                        sp         <= sp + 1;
                        calc_tail  <= calc_in;
                        calc_empty <= 1'b0;
                        calc_valid <= 1'b1;
                    end else begin
                        calc_valid <= 1'b0;
                    end
                end
                OpPop: begin
                    if (sp == 0) begin
                        calc_valid <= 1'b0;
                    end else begin
                        sp         <= sp - 1;
                        calc_tail  <= (sp >= 2) ? stk[sp-2] : 8'h00;
                        calc_empty <= (sp == 1);
                        calc_valid <= 1'b1;
                    end
                end
                OpAdd: begin
                    if (sp == 0) begin
                        calc_valid <= 1'b0;
                    end else begin
                        stk[sp-1]  <= stk[sp-1] + calc_in;
                        calc_tail  <= stk[sp-1] + calc_in;
                        calc_valid <= 1'b1;
                    end
                end
                OpDiv: begin
                    if (sp == 0 || calc_in == 8'h00) begin
                        calc_valid <= 1'b0;
                    end else begin
                        stk[sp-1]  <= stk[sp-1] / calc_in;
                        calc_tail  <= stk[sp-1] / calc_in;
                        calc_valid <= 1'b1;
                    end
                end
                default: calc_valid <= 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] mask, input logic [2:0] op, input logic [7:0] d);
        req_valid = mask;
        for (int i = 0; i < N; i++) begin
            req_op[i*OP_W +: OP_W]     = op;
            req_data[i*DATA_W +: DATA_W] = d;
        end
    endtask

    // Called just after a negedge with the DUT idle; returns at the next idle negedge
    task automatic serve(input logic [N-1:0] mask, input int g, input logic [2:0] op,
                         input logic [7:0] d, input bit hold, input logic [7:0] et,
                         input logic ee, input logic er);
        logic [N-1:0] oh;
        oh = N'(1) << g;
        drive(mask, op, d);
        #1;
        check("req_ready_idle", req_ready, oh);
        check("busy_idle", busy, 0);
        @(negedge clk);
        if (!hold) req_valid = '0;
        check("apply_issue", calc_apply, 1);
        check("calc_in_issue", calc_in, d);
        check("calc_op_issue", calc_op, op);
        check("ready_issue", req_ready, 0);
        for (int k = 0; k < RESP_LAT; k++) begin
            @(negedge clk);
            check("apply_wait", calc_apply, 0);
            check("ready_wait", req_ready, 0);
            check("calc_in_wait", calc_in, d);
            check("rsp_valid_wait", rsp_valid, 0);
        end
        @(negedge clk);
        check("rsp_valid", rsp_valid, oh);
        check("rsp_data", rsp_data, et);
        check("rsp_empty", rsp_empty, ee);
        check("rsp_err", rsp_err, er);
        check("ready_resp", req_ready, 0);
        @(negedge clk);
    endtask

    initial begin
        bit seen;

        // 1. Reset with random inputs
        rst       = 1'b0;
        req_valid = N'($urandom);
        req_op    = (N*OP_W)'($urandom);
        req_data  = $urandom;
        repeat (3) @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_empty", rsp_empty, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_calc_in", calc_in, 0);
        check("rst_calc_op", calc_op, 0);
        check("rst_calc_apply", calc_apply, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        drive('0, OpPush, 8'h00);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (calc_apply || busy) seen = 1'b1;
        end
        check("idle_no_apply", seen, 0);

        // 2. Single requester 2 pushes 0x2A; ptr moves to 3
        serve(4'b0100, 2, OpPush, 8'h2A, 0, 8'h2A, 0, 0);

        // 4. Error paths and recovery; grants walk 3,0,1,2,3
        serve(4'b1000, 3, OpDiv, 8'h00, 0, 8'h2A, 0, 1);
        serve(4'b0001, 0, OpPop, 8'h00, 0, 8'h00, 1, 0);
        serve(4'b0010, 1, OpPop, 8'h00, 0, 8'h00, 1, 1);
        serve(4'b0100, 2, OpPush, 8'h05, 0, 8'h05, 0, 0);
        serve(4'b1000, 3, OpAdd, 8'h03, 0, 8'h08, 0, 0);

        // 5. Withdraw: requester 2 raises then drops valid while busy (ptr=0)
        drive(4'b0010, OpPush, 8'h33);
        #1;
        check("wd_ready_idle", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b0100;
        check("wd_ready_issue", req_ready, 0);
        @(negedge clk);
        check("wd_ready_wait1", req_ready, 0);
        @(negedge clk);
        req_valid = '0;
        check("wd_ready_wait2", req_ready, 0);
        @(negedge clk);
        check("wd_rsp_valid", rsp_valid, 4'b0010);
        check("wd_rsp_data", rsp_data, 8'h33);
        @(negedge clk);
        #1;
        check("wd_no_grant", req_ready, 0);
        check("wd_idle", busy, 0);
        @(negedge clk);
        // ptr must be 2 here, so 0111 grants 2 (a moved ptr would pick 0)
        serve(4'b0111, 2, OpPush, 8'h44, 0, 8'h44, 0, 0);

        // 6. Reset during WAIT (ptr=3, requester 1 granted)
        drive(4'b0010, OpPush, 8'h55);
        #1;
        check("rw_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("rw_in_wait", busy, 1);
        rst = 1'b0;
        #1;
        check("rw_busy", busy, 0);
        check("rw_apply", calc_apply, 0);
        check("rw_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid != '0 || calc_apply) seen = 1'b1;
        end
        check("rw_no_rsp", seen, 0);

        // 3. Fairness after reset: all request, order 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            serve(4'b1111, k % 4, OpPush, 8'(8'h10 + k), 1, 8'(8'h10 + k), 0, 0);
        end
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
